// File: rtl/key_cmd_input_pkg.sv
// -----------------------------------------------------------------------------
// key_cmd_input_pkg
// Shared constants for the pushbutton/switch command path of the pet game:
// key codes, command entry layout {code[11:10], arg[9:0]} and the default
// debounce interval (20 ms at 50 MHz).
// -----------------------------------------------------------------------------
package key_cmd_input_pkg;

    localparam int CMD_W    = 12;
    localparam int CODE_W   = 2;
    localparam int ARG_W    = 10;

    localparam int CODE_MSB = 11;
    localparam int CODE_LSB = 10;
    localparam int ARG_MSB  = 9;
    localparam int ARG_LSB  = 0;

    localparam logic [CODE_W-1:0] KEY0 = 2'd0;
    localparam logic [CODE_W-1:0] KEY1 = 2'd1;
    localparam logic [CODE_W-1:0] KEY2 = 2'd2;
    localparam logic [CODE_W-1:0] KEY3 = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Build one queue entry from a key code and a switch snapshot.
    function automatic logic [CMD_W-1:0] pack_cmd(input logic [CODE_W-1:0] code,
                                                  input logic [ARG_W-1:0]  arg);
        return {code, arg};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces one synchronised key. The accepted level only changes after the
// sampled level has differed from it for DEBOUNCE_CYCLES consecutive cycles;
// any return to the accepted level restarts the count.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   sample  synchronised key level, active-high
//   level   debounced (accepted) key level, active-high
// -----------------------------------------------------------------------------
module key_debounce
    import key_cmd_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sample == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sample;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_cmd_input.sv
// -----------------------------------------------------------------------------
// key_cmd_input
// Turns raw active-low pushbuttons and slide switches into one-per-press
// command tokens: synchronise, debounce, detect press edges, hold a pending
// bit per key, arbitrate lowest key first, and queue {code, switch snapshot}
// in a first-word-fall-through FIFO.
//
// Ports:
//   CLOCK_50   system clock
//   resetn     asynchronous active-low reset
//   key_n      raw pushbuttons, active-low, asynchronous
//   sw         raw slide switches, asynchronous
//   cmd_ready  consumer accepts the head entry
//   clr_ovf    clears the sticky overflow flag
//   cmd_valid  FIFO not empty
//   cmd_code   key index of the head entry (0 when empty)
//   cmd_arg    switch snapshot of the head entry (0 when empty)
//   key_level  debounced key levels, active-high
//   overflow   sticky: a press arrived while the same key was still pending
// -----------------------------------------------------------------------------
module key_cmd_input
    import key_cmd_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [3:0]        key_n,
    input  logic [ARG_W-1:0]  sw,
    input  logic              cmd_ready,
    input  logic              clr_ovf,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic [ARG_W-1:0]  cmd_arg,
    output logic [3:0]        key_level,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [3:0]       key_s1, key_s2;
    logic [ARG_W-1:0] sw_s1, sw_s2;
    logic [3:0]       s_key;
    logic [ARG_W-1:0] s_sw;

    logic [3:0]        level_q;
    logic [3:0]        press;
    logic [3:0]        pending;
    logic [3:0]        grant;
    logic [CODE_W-1:0] grant_idx;

    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push, pop;
    logic [CMD_W-1:0] head;

    // Two-flop synchronisers; keys reset to the released level.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
        end
    end

    assign s_key = ~key_s2;
    assign s_sw  = sw_s2;

    for (genvar g = 0; g < 4; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (CLOCK_50),
            .rst_n (resetn),
            .sample(s_key[g]),
            .level (key_level[g])
        );
    end

    // Only a rising debounced level is a press; releases are ignored.
    assign press = key_level & ~level_q;

    // Lowest-index pending key wins the single enqueue slot.
    always_comb begin
        grant_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) grant_idx = CODE_W'(i);
        end
    end

    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign cmd_valid = (count != '0);
    assign pop       = cmd_valid & cmd_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = (|pending) & (~full | pop);
    assign grant     = push ? (4'b0001 << grant_idx) : 4'b0000;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            level_q  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            level_q <= key_level;
            pending <= (pending & ~grant) | press;
            // A set in the same cycle as clr_ovf takes priority.
            if (|(press & pending)) overflow <= 1'b1;
            else if (clr_ovf)       overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= pack_cmd(grant_idx, s_sw);
    end

    assign head     = mem[rd_ptr];
    assign cmd_code = cmd_valid ? head[CODE_MSB:CODE_LSB] : '0;
    assign cmd_arg  = cmd_valid ? head[ARG_MSB:ARG_LSB]   : '0;

endmodule

// File: tb/tb_key_cmd_input.sv
module tb_key_cmd_input;
    import key_cmd_input_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic        cmd_ready;
    logic        clr_ovf;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic [9:0]  cmd_arg;
    logic [3:0]  key_level;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] sb[$];

    always #5 clk = ~clk;

    key_cmd_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .key_n    (key_n),
        .sw       (sw),
        .cmd_ready(cmd_ready),
        .clr_ovf  (clr_ovf),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_arg  (cmd_arg),
        .key_level(key_level),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!cmd_valid && k < budget) begin
            tick(1);
            k++;
        end
        if (!cmd_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_code"},  32'(cmd_code),  32'd0);
        chk({tag, "_arg"},   32'(cmd_arg),   32'd0);
        chk({tag, "_level"}, 32'(key_level), 32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'd0);
    endtask

    // Scoreboard: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                chk("sb_entry", 32'({cmd_code, cmd_arg}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        key_n     = 4'hF;
        sw        = 10'h3FF;
        cmd_ready = 1'b0;
        clr_ovf   = 1'b0;

        // 1. Reset behaviour
        tick(3);
        check_idle_outputs("rst");
        key_n[1] = 1'b0;
        tick(10);
        check_idle_outputs("rst_key");
        key_n = 4'hF;
        tick(2);
        resetn = 1'b1;
        tick(3);
        check_idle_outputs("post_rst");

        // 2. Clean press, exact latency
        sw = 10'h2A5;
        key_n[1] = 1'b0;
        sb.push_back(pack_cmd(KEY1, 10'h2A5));
        tick(7);
        chk("lat_before", 32'(cmd_valid), 32'd0);
        tick(1);
        chk("lat_valid", 32'(cmd_valid), 32'd1);
        chk("lat_code",  32'(cmd_code),  32'd1);
        chk("lat_arg",   32'(cmd_arg),   32'h2A5);
        chk("lat_level", 32'(key_level), 32'h2);
        tick(3);
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        chk("pop_empty", 32'(cmd_valid), 32'd0);
        chk("pop_code",  32'(cmd_code),  32'd0);
        key_n[1] = 1'b1;
        tick(12);
        chk("release_none",  32'(cmd_valid), 32'd0);
        chk("release_level", 32'(key_level), 32'd0);

        // 3. Bounce
        sw = 10'h155;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) key_n[2] = ~key_n[2];
            tick(1);
            chk("bounce_level", 32'(key_level[2]), 32'd0);
        end
        key_n[2] = 1'b0;
        sb.push_back(pack_cmd(KEY2, 10'h155));
        wait_valid("bounce", 20);
        chk("bounce_code", 32'(cmd_code), 32'd2);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(10);
        chk("bounce_single", 32'(cmd_valid), 32'd0);
        key_n[2] = 1'b1;
        tick(10);

        // 4. Simultaneous press, lowest index first
        sw = 10'h0F0;
        cmd_ready = 1'b1;
        key_n = 4'b0110;
        sb.push_back(pack_cmd(KEY0, 10'h0F0));
        sb.push_back(pack_cmd(KEY3, 10'h0F0));
        tick(8);
        chk("sim_first_valid", 32'(cmd_valid), 32'd1);
        chk("sim_first_code",  32'(cmd_code),  32'd0);
        tick(1);
        chk("sim_second_valid", 32'(cmd_valid), 32'd1);
        chk("sim_second_code",  32'(cmd_code),  32'd3);
        tick(1);
        chk("sim_drained", 32'(cmd_valid), 32'd0);
        chk("sim_ovf",     32'(overflow),  32'd0);
        cmd_ready = 1'b0;
        key_n = 4'hF;
        tick(10);

        // 5. Full FIFO and overflow
        sw = 10'h3C3;
        key_n = 4'b0010;
        sb.push_back(pack_cmd(KEY0, 10'h3C3));
        sb.push_back(pack_cmd(KEY2, 10'h3C3));
        sb.push_back(pack_cmd(KEY3, 10'h3C3));
        tick(12);
        key_n = 4'hF;
        tick(10);
        key_n[0] = 1'b0;
        sb.push_back(pack_cmd(KEY0, 10'h3C3));
        tick(12);
        key_n[0] = 1'b1;
        tick(10);
        key_n[1] = 1'b0;
        sb.push_back(pack_cmd(KEY1, 10'h3C3));
        tick(10);
        chk("full_head_code", 32'(cmd_code), 32'd0);
        chk("full_ovf_clear", 32'(overflow), 32'd0);
        key_n[1] = 1'b1;
        tick(10);
        key_n[1] = 1'b0;
        tick(10);
        chk("ovf_set", 32'(overflow), 32'd1);
        key_n[1] = 1'b1;
        tick(10);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(2);
        chk("refill_valid", 32'(cmd_valid), 32'd1);
        chk("refill_code",  32'(cmd_code),  32'd2);
        cmd_ready = 1'b1;
        tick(8);
        cmd_ready = 1'b0;
        chk("full_drained", 32'(cmd_valid), 32'd0);
        chk("ovf_sticky",   32'(overflow),  32'd1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // 6. Reset mid-operation
        sw = 10'h111;
        key_n = 4'b0011;
        tick(12);
        key_n = 4'hF;
        tick(10);
        key_n[0] = 1'b0;
        tick(3);
        chk("mid_queued", 32'(cmd_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_async_valid", 32'(cmd_valid), 32'd0);
        chk("mid_async_level", 32'(key_level), 32'd0);
        sb.delete();
        tick(2);
        resetn = 1'b1;
        sb.push_back(pack_cmd(KEY0, 10'h111));
        tick(7);
        chk("mid_lat_before", 32'(cmd_valid), 32'd0);
        tick(1);
        chk("mid_lat_valid", 32'(cmd_valid), 32'd1);
        chk("mid_lat_code",  32'(cmd_code),  32'd0);
        chk("mid_lat_arg",   32'(cmd_arg),   32'h111);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        tick(12);
        chk("mid_single", 32'(cmd_valid), 32'd0);
        key_n = 4'hF;
        tick(5);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
